// File: rtl/exu_muldiv.sv
// exu_muldiv: multi-cycle RV32M/RV64M multiply/divide execute stage.
// Radix-2 shift-add multiply, restoring divide, optional one-cycle mul.
module exu_muldiv #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0,
  parameter int TAG_W    = 5
) (
  input  logic             clock,
  input  logic             i_rst_n,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [XLEN-1:0]  i_src2,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [XLEN-1:0]  o_res,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  function automatic logic [XLEN-1:0] sel_res(
    input logic [2:0]        op,
    input logic              neg,
    input logic [2*XLEN-1:0] v
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    p = neg ? -v : v;
    q = neg ? -v[XLEN-1:0] : v[XLEN-1:0];
    r = neg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
    if (!op[2])
      return (op[1:0] == 2'd0) ? p[XLEN-1:0]
                               : p[2*XLEN-1:XLEN];
    return op[1] ? r : q;
  endfunction

  logic accept, is_div, is_rem;
  logic s1_en, s2_en, s1, s2, neg_in;
  logic div0, ovf, spec, fast, last;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] spec_res, fast_res, calc_res;
  logic [2*XLEN-1:0] fast_p, mul_nxt, div_nxt, acc_nxt;
  logic [XLEN:0] mul_sum, div_sh, div_df;
  logic div_ge;

  assign accept = i_pre_valid & o_pre_ready & ~i_flush;
  assign is_div = i_op[2];
  assign is_rem = i_op[2] & i_op[1];
  assign s1_en  = (i_op == 3'd1) | (i_op == 3'd2)
                | (is_div & ~i_op[0]);
  assign s2_en  = (i_op == 3'd1) | (is_div & ~i_op[0]);
  assign s1     = s1_en & i_src1[XLEN-1];
  assign s2     = s2_en & i_src2[XLEN-1];
  assign a_abs  = s1 ? -i_src1 : i_src1;
  assign b_abs  = s2 ? -i_src2 : i_src2;
  assign neg_in = is_rem ? s1 : (s1 ^ s2);

  assign div0 = is_div & (i_src2 == '0);
  assign ovf  = is_div & ~i_op[0]
              & (i_src1 == MIN) & (&i_src2);
  assign spec = div0 | ovf;
  assign fast = FAST_MUL & ~is_div;
  assign spec_res = div0 ? (is_rem ? i_src1 : '1)
                         : (is_rem ? '0 : i_src1);

  if (FAST_MUL) begin : g_fast
    assign fast_p = {{XLEN{1'b0}}, a_abs}
                  * {{XLEN{1'b0}}, b_abs};
  end else begin : g_slow
    assign fast_p = '0;
  end
  assign fast_res = sel_res(i_op, neg_in, fast_p);

  // acc = {partial product, multiplier} or {remainder, quotient}
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                 + (acc[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};
  assign div_sh  = acc[2*XLEN-1:XLEN-1];
  assign div_df  = div_sh - {1'b0, opnd_q};
  assign div_ge  = ~div_df[XLEN];
  assign div_nxt = {div_ge ? div_df[XLEN-1:0]
                           : div_sh[XLEN-1:0],
                    acc[XLEN-2:0], div_ge};
  assign acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
  assign last     = (cnt == CW'(XLEN-1));
  assign calc_res = sel_res(op_q, neg_q, acc_nxt);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)
              state_nxt = (spec | fast) ? DONE : CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (o_post_valid & i_post_ready)
              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_pre_ready  <= 1'b0;
      o_post_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_pre_ready  <= (state_nxt == IDLE);
      o_post_valid <= (state == DONE)
                    & (state_nxt == DONE);
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      o_res  <= '0;
      o_tag  <= '0;
    end else if (accept) begin
      op_q   <= i_op;
      neg_q  <= neg_in;
      opnd_q <= is_div ? b_abs : a_abs;
      acc    <= {{XLEN{1'b0}},
                 is_div ? a_abs : b_abs};
      cnt    <= '0;
      o_tag  <= i_tag;
      if (spec)      o_res <= spec_res;
      else if (fast) o_res <= fast_res;
    end else if (state == CALC && !i_flush) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) o_res <= calc_res;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: random and directed checks of exu_muldiv against
// an arithmetic reference model (32-bit iterative, 64-bit fast mul).
module tb_exu_muldiv;

  logic clock;
  logic rst_n;
  logic [1:0]       pre_valid, pre_ready;
  logic [1:0]       post_valid, post_ready;
  logic [1:0]       flush, busy;
  logic [1:0][2:0]  op;
  logic [1:0][63:0] src1, src2;
  logic [1:0][4:0]  tag_in, tag_out;
  logic [31:0]      res32;
  logic [63:0]      res64;
  int checks, fails;

  exu_muldiv #(.XLEN(32), .FAST_MUL(1'b0), .TAG_W(5)) u_x32 (
    .clock(clock), .i_rst_n(rst_n),
    .i_pre_valid(pre_valid[0]), .o_pre_ready(pre_ready[0]),
    .i_op(op[0]), .i_src1(src1[0][31:0]),
    .i_src2(src2[0][31:0]), .i_tag(tag_in[0]),
    .i_flush(flush[0]), .o_post_valid(post_valid[0]),
    .i_post_ready(post_ready[0]), .o_res(res32),
    .o_tag(tag_out[0]), .o_busy(busy[0]));

  exu_muldiv #(.XLEN(64), .FAST_MUL(1'b1), .TAG_W(5)) u_x64 (
    .clock(clock), .i_rst_n(rst_n),
    .i_pre_valid(pre_valid[1]), .o_pre_ready(pre_ready[1]),
    .i_op(op[1]), .i_src1(src1[1]), .i_src2(src2[1]),
    .i_tag(tag_in[1]), .i_flush(flush[1]),
    .o_post_valid(post_valid[1]),
    .i_post_ready(post_ready[1]), .o_res(res64),
    .o_tag(tag_out[1]), .o_busy(busy[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] res_of(input int d);
    return d ? res64 : {32'd0, res32};
  endfunction

  function automatic logic [63:0] model(input int xl,
    input logic [2:0] o, input logic [63:0] a,
    input logic [63:0] b);
    logic signed [129:0] ua, ub, sa, sb, p;
    logic [63:0] m;
    m  = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    ua = {66'd0, a & m};
    ub = {66'd0, b & m};
    sa = a[xl-1] ? ua - (130'sd1 <<< xl) : ua;
    sb = b[xl-1] ? ub - (130'sd1 <<< xl) : ub;
    p  = 0;
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> xl;
      3'd2: p = (sa * ub) >>> xl;
      3'd3: p = (ua * ub) >>> xl;
      3'd4: if (ub == 0) p = -1; else p = sa / sb;
      3'd5: if (ub == 0) p = -1; else p = ua / ub;
      3'd6: if (ub == 0) p = ua; else p = sa % sb;
      default: if (ub == 0) p = ua; else p = ua % ub;
    endcase
    return p[63:0] & m;
  endfunction

  task automatic do_op(input int d, input logic [2:0] o,
    input logic [63:0] a_i, input logic [63:0] b_i,
    input logic [4:0] t, input int bp,
    output logic [63:0] r);
    int xl, lat, k;
    logic [63:0] m, a, b, e;
    xl = d ? 64 : 32;
    m  = d ? '1 : 64'hFFFF_FFFF;
    a  = a_i & m;
    b  = b_i & m;
    e  = model(xl, o, a, b);
    lat = xl + 1;
    if (o[2] && b == 0) lat = 1;
    if (o[2] && !o[0] && a == (64'd1 << (xl-1)) && b == m)
      lat = 1;
    if (d == 1 && !o[2]) lat = 1;
    k = 0;
    while (!pre_ready[d] && k < 100) begin
      @(negedge clock); k++;
    end
    check("acc_rdy", {63'd0, pre_ready[d]}, 64'd1);
    op[d] = o; src1[d] = a; src2[d] = b;
    tag_in[d] = t; pre_valid[d] = 1'b1;
    @(negedge clock);
    pre_valid[d] = 1'b0;
    check("busy", {63'd0, busy[d]}, 64'd1);
    k = 0;
    while (!post_valid[d] && k < 200) begin
      @(negedge clock); k++;
    end
    check("latency", 64'(k), 64'(lat));
    check("res", res_of(d), e);
    check("tag", {59'd0, tag_out[d]}, {59'd0, t});
    r = res_of(d);
    for (int i = 0; i < bp; i++) begin
      pre_valid[d] = 1'b1;
      op[d] = ~o;
      @(negedge clock);
      check("bp_valid", {63'd0, post_valid[d]}, 64'd1);
      check("bp_rdy", {63'd0, pre_ready[d]}, 64'd0);
      check("bp_res", res_of(d), e);
      check("bp_tag", {59'd0, tag_out[d]}, {59'd0, t});
    end
    pre_valid[d] = 1'b0;
    post_ready[d] = 1'b1;
    @(negedge clock);
    post_ready[d] = 1'b0;
    check("hs_valid", {63'd0, post_valid[d]}, 64'd0);
    check("hs_rdy", {63'd0, pre_ready[d]}, 64'd1);
    check("hs_busy", {63'd0, busy[d]}, 64'd0);
  endtask

  function automatic logic [63:0] pick(input int d);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return d ? 64'h8000_0000_0000_0000
                  : 64'h8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r, prev;
    logic seen;
    int d;
    checks = 0; fails = 0;
    rst_n = 1'b0;
    pre_valid = '0; post_ready = '0; flush = '0;
    op = '0; src1 = '0; src2 = '0; tag_in = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("rst_rdy", {63'd0, pre_ready[i]}, 64'd0);
      check("rst_val", {63'd0, post_valid[i]}, 64'd0);
      check("rst_res", res_of(i), 64'd0);
      check("rst_tag", {59'd0, tag_out[i]}, 64'd0);
      check("rst_busy", {63'd0, busy[i]}, 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rdy_hold", {63'd0, pre_ready[0]}, 64'd0);
    @(negedge clock);
    check("rdy_up0", {63'd0, pre_ready[0]}, 64'd1);
    check("rdy_up1", {63'd0, pre_ready[1]}, 64'd1);

    do_op(0, 3'd0, 7, 6, 5'd3, 0, r);
    check("mul7x6", r, 64'd42);
    do_op(0, 3'd3, '1, '1, 5'd1, 0, r);
    check("mulhu", r, 64'hFFFF_FFFE);
    do_op(0, 3'd1, '1, '1, 5'd2, 0, r);
    check("mulh", r, 64'd0);
    do_op(0, 3'd2, '1, 2, 5'd4, 0, r);
    check("mulhsu", r, 64'hFFFF_FFFF);
    do_op(0, 3'd4, 64'hFFFF_FFF9, 2, 5'd5, 0, r);
    check("div_m7", r, 64'hFFFF_FFFD);
    do_op(0, 3'd6, 64'hFFFF_FFF9, 2, 5'd6, 0, r);
    check("rem_m7", r, 64'hFFFF_FFFF);
    do_op(0, 3'd5, 5, 0, 5'd7, 0, r);
    check("divu0", r, 64'hFFFF_FFFF);
    do_op(0, 3'd7, 5, 0, 5'd8, 0, r);
    check("remu0", r, 64'd5);
    do_op(0, 3'd4, 64'h8000_0000, '1, 5'd9, 0, r);
    check("div_ovf", r, 64'h8000_0000);
    do_op(0, 3'd6, 64'h8000_0000, '1, 5'd10, 0, r);
    check("rem_ovf", r, 64'd0);
    do_op(0, 3'd0, 123, 45, 5'd11, 5, r);
    check("bp_mul", r, 64'd5535);
    do_op(1, 3'd0, 64'h1_0000_0000, 3, 5'd12, 0, r);
    check("mul64", r, 64'h3_0000_0000);
    do_op(1, 3'd5, 100, 7, 5'd13, 0, r);
    check("divu64", r, 64'd14);

    prev = res_of(0);
    op[0] = 3'd0; src1[0] = 11; src2[0] = 13;
    tag_in[0] = 5'd14; pre_valid[0] = 1'b1;
    @(negedge clock);
    pre_valid[0] = 1'b0;
    repeat (9) @(negedge clock);
    check("calc_busy", {63'd0, busy[0]}, 64'd1);
    flush[0] = 1'b1;
    @(negedge clock);
    flush[0] = 1'b0;
    check("fl_busy", {63'd0, busy[0]}, 64'd0);
    check("fl_rdy", {63'd0, pre_ready[0]}, 64'd1);
    check("fl_res", res_of(0), prev);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (post_valid[0]) seen = 1'b1;
    end
    check("fl_noval", {63'd0, seen}, 64'd0);

    flush[0] = 1'b1; pre_valid[0] = 1'b1;
    @(negedge clock);
    flush[0] = 1'b0; pre_valid[0] = 1'b0;
    check("flv_busy", {63'd0, busy[0]}, 64'd0);
    check("flv_rdy", {63'd0, pre_ready[0]}, 64'd1);

    op[0] = 3'd5; src1[0] = 99; src2[0] = 4;
    tag_in[0] = 5'd15; pre_valid[0] = 1'b1;
    @(negedge clock);
    pre_valid[0] = 1'b0;
    repeat (5) @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("mr_rdy", {63'd0, pre_ready[0]}, 64'd0);
    check("mr_val", {63'd0, post_valid[0]}, 64'd0);
    check("mr_res", res_of(0), 64'd0);
    check("mr_tag", {59'd0, tag_out[0]}, 64'd0);
    check("mr_busy", {63'd0, busy[0]}, 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("mr_rdy1", {63'd0, pre_ready[0]}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (post_valid[0]) seen = 1'b1;
    end
    check("mr_noval", {63'd0, seen}, 64'd0);

    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 1));
      do_op(d, 3'($urandom_range(0, 7)), pick(d), pick(d),
            5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
Parametrised multi-cycle execute unit implementing the RV32M/RV64M multiply/divide ops alongside the single-cycle ALU path.
- Iterative radix-2 shift-add multiplier and restoring divider, with a registered result.
- Uses the stage valid/ready handshake (pre = IDU side, post = WBU side).
- Carries a destination-register tag, supports pipeline flush, and optionally uses a single-cycle multiplier.

Parameters:
XLEN, 32, operand/result width (32 or 64).
FAST_MUL, 0, 1 = multiply ops complete in one cycle using the `*` operator; 0 = iterative multiply.
TAG_W, 5, width of the destination tag carried through.

Ports:
clock  in  1  clock.
i_rst_n  in  1  reset, asynchronous, active-low.
i_pre_valid  in  1  upstream operation valid.
o_pre_ready  out  1  unit can accept an operation (registered).
i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
i_src1  in  XLEN  rs1 operand (multiplicand / dividend).
i_src2  in  XLEN  rs2 operand (multiplier / divisor).
i_tag  in  TAG_W  destination tag.
i_flush  in  1  synchronous abandon of the current operation.
o_post_valid  out  1  result valid.
i_post_ready  in  1  downstream accepts result.
o_res  out  XLEN  result.
o_tag  out  TAG_W  tag of the result.
o_busy  out  1  state != IDLE.

Behaviour:
Reset values:
- state = IDLE, o_pre_ready = 0, o_post_valid = 0, o_res = 0, o_tag = 0.
- o_pre_ready rises on the first clock edge after reset release.

FSM states: IDLE, CALC, DONE.
- Accept = i_pre_valid & o_pre_ready & ~i_flush, sampled at the clock edge.
- On accept: latch op/tag; drop o_pre_ready.
- State after accept:
  - CALC in the normal case.
  - DONE directly for special cases.
  - DONE directly for mul ops when FAST_MUL = 1.

Operand preparation at accept:
- Take the absolute value of each signed operand: DIV/REM both operands; MULH both operands; MULHSU rs1 only.
- Record the result sign:
  - mul: XOR of the operand signs.
  - DIV: XOR of the operand signs.
  - REM: sign of the dividend.

CALC:
- A counter runs XLEN iterations, one bit per cycle.
- Multiply: 2*XLEN-bit accumulator.
- Divide: restoring, XLEN-bit quotient plus XLEN-bit remainder.
- After the last iteration:
  - Apply sign correction (negate the full 2*XLEN product, or the quotient/remainder).
  - Select the result: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Go to DONE with o_post_valid = 1.
- Latency: o_post_valid asserted XLEN+1 edges after the accept edge.

Special cases (resolved at accept; valid 1 edge later):
- Divisor 0: DIV/DIVU -> all ones; REM/REMU -> src1.
- Signed overflow, src1 = 1<<(XLEN-1) and src2 = -1: DIV -> src1; REM -> 0.

DONE:
- o_res/o_tag held stable until i_post_ready.
- On handshake: o_post_valid = 0, state = IDLE, o_pre_ready = 1 on the same edge.
- No new operation is accepted while in DONE (no overlap).

i_flush:
- In any state: next edge forces IDLE, o_post_valid = 0, o_pre_ready = 1. o_res keeps its old value.
- Flush wins over a simultaneous accept or handshake.

Reset asserted mid-operation: immediate return to reset values; no result is produced.

Back-pressure: indefinite; no state advances while in DONE.

Test Plan:
- XLEN=32, FAST_MUL=0: MUL 7*6, tag 3 -> o_res = 42, o_tag = 3, o_post_valid at edge 33 after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both valid 1 edge after accept; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
- Back-pressure: hold i_post_ready = 0 for 5 cycles in DONE -> o_res/o_tag stable, o_pre_ready = 0, upstream valid not accepted; release -> IDLE, ready = 1.
- i_flush at CALC iteration 10 -> IDLE next edge, no o_post_valid; flush coinciding with i_pre_valid in IDLE -> not accepted. Reset pulse mid-CALC -> all outputs 0, ready 1 after release.
- FAST_MUL=1, XLEN=64: MUL 0x1_0000_0000*3 -> 0x3_0000_0000 valid 1 edge after accept; DIVU 100/7 -> 14 after 65 edges.
